// File: rtl/basamak_pkg.sv
// Shared constants, buffer state encoding and decode helpers for the
// bit-position decoder (basamak_uretme) and its output buffer.
package basamak_pkg;

   localparam int unsigned BASAMAK_WIDTH = 3;
   localparam int unsigned BASAMAK_IDXW  = 2;

   // Occupancy of the 2-entry output buffer
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } tampon_state_t;

   // The all-ones position code, reserved for "no set bit"
   function automatic int unsigned none_code(input int unsigned idxw);
      return (32'd1 << idxw) - 32'd1;
   endfunction

   // One bit of the one-hot word: set only where the index equals the code
   function automatic logic decode_bit(input int unsigned pos, input int unsigned idx);
      return (pos == idx);
   endfunction

   // Code falls outside the word, so no bit is set
   function automatic logic decode_none(input int unsigned pos, input int unsigned width);
      return (pos >= width);
   endfunction

   // One bit of the thermometer mask below the set bit; all ones for a none code
   function automatic logic mask_bit(input int unsigned pos, input int unsigned idx,
                                     input int unsigned width);
      return (pos >= width) || (idx < pos);
   endfunction

endpackage

// File: rtl/basamak_tampon.sv
// Generic 2-entry valid/ready FIFO buffer. in_ready depends only on the
// registered occupancy, so there is no combinational path from out_ready.
// The head entry drives dout directly and holds its value when empty.
module basamak_tampon
   import basamak_pkg::*;
#(
   parameter int unsigned DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] din,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] dout
);

   tampon_state_t     state, state_nxt;
   logic              push, pop;
   logic [DATA_W-1:0] head_p0;
   logic [DATA_W-1:0] tail_p1;

   // Occupancy state register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_nxt;
   end

   // Occupancy transitions on push/pop; never wraps past FULL or below EMPTY
   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (push) state_nxt = ONE;
         ONE:     if (push && !pop) state_nxt = FULL;
                  else if (!push && pop) state_nxt = EMPTY;
         FULL:    if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // Handshake outputs decoded from the registered occupancy only
   always_comb begin
      in_ready  = (state != FULL);
      out_valid = (state != EMPTY);
      push      = in_valid && in_ready;
      pop       = out_valid && out_ready;
   end

   // Entry storage: head feeds the output, tail shifts up when the head leaves
   always_ff @(posedge clk) begin
      if (rst) begin
         head_p0 <= '0;
      end else begin
         case (state)
            EMPTY: if (push) head_p0 <= din;
            ONE: begin
               if (push && pop) head_p0 <= din;
               else if (push)   tail_p1 <= din;
            end
            FULL:  if (pop) head_p0 <= tail_p1;
            default: ;
         endcase
      end
   end

   assign dout = head_p0;

endmodule

// File: rtl/basamak_uretme.sv
// Bit-position decoder: turns a position code into the matching one-hot
// word (all-ones code -> zero word with out_none), buffered through a
// 2-entry valid/ready FIFO. Define BASAMAK_MASKE_EN to add out_mask, the
// thermometer mask of positions below the set bit.
module basamak_uretme
   import basamak_pkg::*;
#(
   parameter int unsigned WIDTH = BASAMAK_WIDTH,
   parameter int unsigned IDXW  = BASAMAK_IDXW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IDXW-1:0]  in_pos,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_word,
`ifdef BASAMAK_MASKE_EN
   output logic [WIDTH-1:0] out_mask,
`endif
   output logic             out_none
);

`ifdef BASAMAK_MASKE_EN
   localparam int unsigned DATA_W = 2 * WIDTH + 1;
`else
   localparam int unsigned DATA_W = WIDTH + 1;
`endif

   logic [WIDTH-1:0]  dec_word;
   logic              dec_none;
   logic [DATA_W-1:0] din, dout;

   // Decode the incoming code before it enters the buffer
   always_comb begin
      dec_word = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         dec_word[i] = decode_bit(32'(in_pos), i);
      dec_none = decode_none(32'(in_pos), WIDTH);
   end

`ifdef BASAMAK_MASKE_EN
   logic [WIDTH-1:0] dec_mask;

   // Thermometer mask travels with the word
   always_comb begin
      dec_mask = '0;
      for (int unsigned i = 0; i < WIDTH; i++)
         dec_mask[i] = mask_bit(32'(in_pos), i, WIDTH);
   end

   assign din = {dec_mask, dec_none, dec_word};
   assign {out_mask, out_none, out_word} = dout;
`else
   assign din = {dec_none, dec_word};
   assign {out_none, out_word} = dout;
`endif

   basamak_tampon #(
      .DATA_W (DATA_W)
   ) u_tampon (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout)
   );

endmodule

// File: tb/tb_basamak_uretme.sv
// Scoreboard bench for basamak_uretme (WIDTH=3, IDXW=2): expected results
// are queued on accept and compared against the head while results are held.
module tb_basamak_uretme;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_pos = 2'd0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_word;
   logic         out_none;
`ifdef BASAMAK_MASKE_EN
   logic [W-1:0] out_mask;
`endif

   int total = 0;
   int bad   = 0;

   // Expected entry: {mask, none, word}
   logic [2*W:0] sb[$];

   always #5 clk = ~clk;

   basamak_uretme dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pos    (in_pos),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
`ifdef BASAMAK_MASKE_EN
      .out_mask  (out_mask),
`endif
      .out_none  (out_none)
   );

   task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*W:0] model(input logic [1:0] pos);
      logic [W-1:0] w, m;
      logic n;
      if (pos < W) begin
         w = W'(1) << pos;
         m = w - W'(1);
         n = 1'b0;
      end else begin
         w = '0;
         m = '1;
         n = 1'b1;
      end
      return {m, n, w};
   endfunction

   // Monitor: check head and handshake at negedge, then apply the upcoming edge
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         kontrol("in_ready", 32'(in_ready), 32'(sb.size() != 2));
         kontrol("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            kontrol("out_word", 32'(out_word), 32'(sb[0][W-1:0]));
            kontrol("out_none", 32'(out_none), 32'(sb[0][W]));
`ifdef BASAMAK_MASKE_EN
            kontrol("out_mask", 32'(out_mask), 32'(sb[0][2*W:W+1]));
`endif
         end
         if (sb.size() != 0 && out_ready) void'(sb.pop_front());
         if (in_valid && in_ready) sb.push_back(model(in_pos));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int k = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while (sb.size() != 0 && k < 20) begin
         cyc();
         k++;
      end
      kontrol("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // Reset, then idle
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(2);
      kontrol("rst_out_valid", 32'(out_valid), 32'd0);
      kontrol("rst_out_word", 32'(out_word), 32'd0);
      kontrol("rst_out_none", 32'(out_none), 32'd0);
      kontrol("rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back codes 0..3, consumer always ready
      out_ready = 1'b1;
      for (int p = 0; p < 4; p++) begin
         in_valid = 1'b1;
         in_pos   = 2'(p);
         cyc();
         kontrol("b2b_out_valid", 32'(out_valid), 32'd1);
         kontrol("b2b_word", 32'(out_word), 32'(model(2'(p)) & 7'h07));
      end
      drain();

      // Stall: fill both entries, in_ready drops, head held
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pos    = 2'd1;
      cyc();
      in_pos = 2'd2;
      cyc();
      in_valid = 1'b0;
      kontrol("full_in_ready", 32'(in_ready), 32'd0);
      cyc(3);
      kontrol("stall_word", 32'(out_word), 32'h2);
      kontrol("stall_valid", 32'(out_valid), 32'd1);
      drain();
      kontrol("after_full_in_ready", 32'(in_ready), 32'd1);

      // Simultaneous push and pop with one entry buffered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pos    = 2'd2;
      cyc();
      out_ready = 1'b1;
      in_pos    = 2'd0;
      cyc();
      in_valid = 1'b0;
      kontrol("pp_word", 32'(out_word), 32'h1);
      kontrol("pp_in_ready", 32'(in_ready), 32'd1);
      drain();

      // Reset with two entries buffered flushes them
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_pos    = 2'd1;
      cyc();
      in_pos = 2'd0;
      cyc();
      in_valid = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      kontrol("flush_out_valid", 32'(out_valid), 32'd0);
      kontrol("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pos    = 2'd2;
      cyc();
      in_valid = 1'b0;
      kontrol("flush_word", 32'(out_word), 32'h4);
      drain();

`ifdef BASAMAK_MASKE_EN
      // Mask values for pos 2, 0, 3
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_pos = 2'd2; cyc(); kontrol("mask_p2", 32'(out_mask), 32'h3);
      in_pos = 2'd0; cyc(); kontrol("mask_p0", 32'(out_mask), 32'h0);
      in_pos = 2'd3; cyc(); kontrol("mask_p3", 32'(out_mask), 32'h7);
      drain();
`endif

      // Random traffic with random back-pressure
      for (int i = 0; i < 300; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         in_pos    = 2'($urandom_range(0, 3));
         cyc();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/basamak_uretme.md
Name: basamak_uretme

Overview:
- Inverse of the digit-position encoder: takes a bit-position code and produces the corresponding one-hot word of WIDTH bits.
- The all-ones code (3 for WIDTH=3) means "no set bit" and yields a zero word with the out_none flag set.
- Valid/ready on both sides, with a 2-entry output buffer so back-pressure never drops a request.
- Sits downstream of the position encoder, rebuilding the original lowest-set-bit word for the next arithmetic stage.

Parameters:
- WIDTH, 3, output word width (number of digit positions)
- IDXW, 2, position code width; must satisfy 2^IDXW > WIDTH so at least one "none" code exists

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_pos  input  IDXW  bit-position code
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_word  output  WIDTH  one-hot word, bit in_pos set
- out_none  output  1  code was out of range (in_pos >= WIDTH)

Behaviour:
- Synchronous, active-high reset; one clock, clk.
- Reset values: out_valid=0, out_word=0, out_none=0, buffer count=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation flushes both buffer entries; pending results are lost.
- Accept: in_valid & in_ready at an edge.
- Deliver: out_valid & out_ready at an edge.
- Decode: in_pos < WIDTH gives out_word = 1 << in_pos and out_none=0.
- Decode: in_pos >= WIDTH gives out_word = 0 and out_none=1.
- No X propagation for any code.
- Latency: request accepted at edge t appears with out_valid=1 after edge t; 1 cycle.
- Throughput: 1 result per cycle while out_ready stays high.
- Buffer: 2 entries, FIFO order. in_ready = (count != 2), registered-count based, no combinational path from out_ready.
- Buffer empty: out_valid=0; out_word and out_none hold their last values (don't-care to the consumer).
- Buffer full (count=2): in_ready=0 even if a pop occurs in the same cycle. Accepted loss of throughput; no bypass.
- Simultaneous push and pop with count=1: count stays 1, new entry becomes head next cycle.
- Stall rule: while out_valid & !out_ready, out_word and out_none are held stable.
- Stall rule: out_valid never deasserts without a delivery.
- Internal states: EMPTY (0), ONE (1), FULL (2), driven by a count with push/pop transitions. The count never wraps past 2 or below 0.

Optional Feature:
- Macro: BASAMAK_MASKE_EN.
- When defined, adds output out_mask [WIDTH-1:0], buffered alongside out_word. It carries the thermometer mask of positions below in_pos, i.e. (1<<in_pos)-1. For a none code it is all ones.
- This reproduces the trailing-zero region counted by the encoder.
- When undefined, the port and its storage are absent; all other behaviour is identical.

Decomposition:
- Package basamak_pkg:
  - default WIDTH/IDXW constants
  - function computing the none code (2^IDXW-1)
  - pure decode function (pos -> word, none)
- One sub-module, basamak_tampon: a generic 2-entry valid/ready buffer parameterised by data width. It carries {out_none, out_word} (plus out_mask when enabled).

Test Plan:
- Reset then idle -> out_valid=0, out_word=3'b000, out_none=0, in_ready=1.
- in_pos = 0, 1, 2, 3 back-to-back with out_ready=1 -> one cycle later, one per cycle: 3'b001, 3'b010, 3'b100, then 3'b000 with out_none=1.
- out_ready=0, push pos=1 then pos=2 -> in_ready=0 after the second accept, out_word holds 3'b010. Raise out_ready -> 3'b010 then 3'b100 in order, in_ready returns to 1.
- count=1 with simultaneous push pos=0 and pop -> next cycle out_word=3'b001, count stays 1, no loss or duplication.
- Assert rst while 2 entries are buffered -> next cycle out_valid=0, in_ready=1; a following pos=2 yields 3'b100 only.
- With BASAMAK_MASKE_EN: pos=2 -> out_mask=3'b011; pos=0 -> 3'b000; pos=3 -> 3'b111.
